// File: rtl/dongle_pkg.sv
// dongle_pkg: shared mode encoding and config-select constants for the cartridge dongle.
package dongle_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'd0,
    MODE_CNT  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;
  localparam logic CFG_SEL_SEED = 1'b0;
  localparam logic CFG_SEL_TAP  = 1'b1;
endpackage

// File: rtl/cart_strobe_sync.sv
// cart_strobe_sync: 2-flop synchroniser for the async ROM select strobe, plus one-clk rise pulse.
module cart_strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_n_i,
  output logic sel_s_o,
  output logic rise_o
);
  logic s1_q, s2_q, d_q;
  // Flops reset to idle-high so reset release never fakes an access edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {s1_q, s2_q, d_q} <= 3'b111;
    else {s1_q, s2_q, d_q} <= {sel_n_i, s1_q, s2_q};
  end
  assign sel_s_o = s2_q;
  assign rise_o  = s2_q & ~d_q;
endmodule

// File: rtl/cart_lfsr_dongle.sv
// cart_lfsr_dongle: Atari ST cartridge copy-protection dongle emulator (counter/LFSR key state).
// Define CART_DONGLE_CFG_EN to make seed and tap registers writable through cfg_*.
module cart_lfsr_dongle
  import dongle_pkg::*;
#(
  parameter int                 STATE_W  = 16,
  parameter int                 DATA_W   = 1,
  parameter int                 ADDR_W   = 2,
  parameter logic [STATE_W-1:0] TAP_MASK = 16'hB400,
  parameter logic [STATE_W-1:0] SEED     = 16'h0001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rom_sel_n,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [MODE_W-1:0]  mode,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [STATE_W-1:0] cfg_data,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_oe,
  output logic [STATE_W-1:0] state_q
);
  logic sel_s, rise, wr_seed, wr_hold, inj, reload;
  logic [ADDR_W-1:0] addr_cap_q, addr_cap_d;
  logic [STATE_W-1:0] state_d, seed, taps, seed_wr, cnt_nxt, lfsr_nxt, upd;
  mode_e m;

  cart_strobe_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .sel_n_i (rom_sel_n),
    .sel_s_o (sel_s),
    .rise_o  (rise)
  );

`ifdef CART_DONGLE_CFG_EN
  logic [STATE_W-1:0] seed_q, taps_q;
  assign wr_hold = cfg_we;
  assign wr_seed = cfg_we && cfg_sel == CFG_SEL_SEED;
  assign seed_wr = cfg_data == '0 ? SEED : cfg_data;
  assign seed    = seed_q;
  assign taps    = taps_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q <= SEED;
      taps_q <= TAP_MASK;
    end else begin
      if (wr_seed) seed_q <= seed_wr;
      if (cfg_we && cfg_sel == CFG_SEL_TAP && cfg_data != '0) taps_q <= cfg_data;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data};
  assign wr_hold    = 1'b0;
  assign wr_seed    = 1'b0;
  assign seed_wr    = SEED;
  assign seed       = SEED;
  assign taps       = TAP_MASK;
`endif

  always_comb begin
    m          = mode_e'(mode);
    addr_cap_d = sel_s ? addr_cap_q : addr;
    inj        = addr_cap_q[0];
    reload     = &addr_cap_q[ADDR_W-1:1];
    cnt_nxt    = state_q + STATE_W'(1) + STATE_W'(inj);
    lfsr_nxt   = {state_q[STATE_W-2:0], ^(state_q & taps) ^ inj};
    // Reload applies in every active mode; an all-zero LFSR result would lock up, so reseed.
    upd        = m == MODE_OFF ? state_q :
                 reload ? seed :
                 m == MODE_CNT ? cnt_nxt :
                 m == MODE_HOLD ? state_q :
                 lfsr_nxt == '0 ? seed : lfsr_nxt;
    state_d    = wr_seed ? seed_wr : (rise && !wr_hold) ? upd : state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEED;
      addr_cap_q <= '0;
      data_out   <= SEED[STATE_W-1 -: DATA_W];
      data_oe    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cap_q <= addr_cap_d;
      data_out   <= state_q[STATE_W-1 -: DATA_W];
      data_oe    <= ~sel_s & (m != MODE_OFF);
    end
  end
endmodule
